// File: rtl/trig_burst_gen.sv
// trig_burst_gen: burst of fixed-width trigger pulses started by a rising edge of I_Trig_in
//   I_clk, I_Rst_n           : clock, synchronous active-low reset
//   I_Trig_in                : start request (rising edge, accepted only when idle)
//   I_Trig_Num/Step, I_Delay : pulse count, pulse period, start delay (latched at start)
//   I_Abort                  : ends an active burst without O_Done
//   O_Trig, O_Busy, O_Done   : pulse output, burst active, completion strobe
//   O_Pulse_Cnt              : pulses issued in the current/last burst
module trig_burst_gen #(
    parameter int PULSE_W = 4,
    parameter int DLY_W   = 16
) (
    input  logic             I_clk,
    input  logic             I_Rst_n,
    input  logic             I_Trig_in,
    input  logic [31:0]      I_Trig_Num,
    input  logic [31:0]      I_Trig_Step,
    input  logic [DLY_W-1:0] I_Delay,
    input  logic             I_Abort,
    output logic             O_Trig,
    output logic             O_Busy,
    output logic             O_Done,
    output logic [31:0]      O_Pulse_Cnt
);
    typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, DONE} state_t;
    state_t      state_q, state_d;
    logic        trig_prev_q, trig_prev_d;
    logic [31:0] num_q, num_d, step_q, step_d, tmr_q, tmr_d, cnt_q, cnt_d;
    logic        rise;
    logic [31:0] gap_len;
    always_comb begin
        rise        = I_Trig_in & ~trig_prev_q;
        // step <= PULSE_W still leaves one low cycle between pulses
        gap_len     = ({1'b0, step_q} > 33'(PULSE_W)) ? step_q - 32'(PULSE_W) : 32'd1;
        trig_prev_d = I_Trig_in;
        state_d     = state_q;
        num_d       = num_q;
        step_d      = step_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (rise) begin
                num_d   = I_Trig_Num;
                step_d  = I_Trig_Step;
                cnt_d   = '0;
                tmr_d   = (I_Delay == '0) ? 32'(PULSE_W - 1) : 32'(I_Delay) - 32'd1;
                state_d = (I_Trig_Num == '0) ? DONE : (I_Delay != '0) ? DELAY : PULSE;
            end
            DELAY: begin
                if (I_Abort) state_d = IDLE;
                else if (tmr_q == '0) begin
                    state_d = PULSE;
                    tmr_d   = 32'(PULSE_W - 1);
                end else tmr_d = tmr_q - 32'd1;
            end
            PULSE: begin
                if (I_Abort) state_d = IDLE;
                else begin
                    // count lands at the end of the first high cycle
                    if (tmr_q == 32'(PULSE_W - 1)) cnt_d = cnt_q + 32'd1;
                    if (tmr_q == '0) begin
                        state_d = (cnt_d == num_q) ? DONE : GAP;
                        tmr_d   = gap_len - 32'd1;
                    end else tmr_d = tmr_q - 32'd1;
                end
            end
            GAP: begin
                if (I_Abort) state_d = IDLE;
                else if (tmr_q == '0) begin
                    state_d = PULSE;
                    tmr_d   = 32'(PULSE_W - 1);
                end else tmr_d = tmr_q - 32'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge I_clk) begin
        if (!I_Rst_n) begin
            state_q     <= IDLE;
            trig_prev_q <= 1'b0;
            num_q       <= '0;
            step_q      <= '0;
            tmr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig_prev_d;
            num_q       <= num_d;
            step_q      <= step_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
        end
    end
    assign O_Trig      = state_q == PULSE;
    assign O_Busy      = (state_q == DELAY) || (state_q == PULSE) || (state_q == GAP);
    assign O_Done      = state_q == DONE;
    assign O_Pulse_Cnt = cnt_q;
endmodule

// File: tb/tb_trig_burst_gen.sv
// tb_trig_burst_gen: directed bench for trig_burst_gen with PULSE_W=4
module tb_trig_burst_gen;
    logic        clk = 1'b0;
    logic        rst_n, trig_in, abort;
    logic [31:0] num, stp;
    logic [15:0] dly;
    logic        o_trig, o_busy, o_done;
    logic [31:0] o_cnt;
    int          checks = 0, errors = 0, cyc = 0;

    always #4 clk = ~clk;

    trig_burst_gen #(.PULSE_W(4), .DLY_W(16)) dut (
        .I_clk(clk), .I_Rst_n(rst_n), .I_Trig_in(trig_in), .I_Trig_Num(num),
        .I_Trig_Step(stp), .I_Delay(dly), .I_Abort(abort), .O_Trig(o_trig),
        .O_Busy(o_busy), .O_Done(o_done), .O_Pulse_Cnt(o_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the rise cycle T; checks cycles T+1 .. a few past O_Done.
    // rr != 0 re-raises I_Trig_in for one cycle at T+rr (must be ignored).
    task automatic check_burst(input int n, input int s, input int d, input int rr);
        int p, first, last, len, hi, pc;
        p     = (s > 4) ? s : 5;
        first = 1 + d;
        last  = (n == 0) ? 0 : first + (n - 1) * p;
        len   = (n == 0) ? 4 : last + 7;
        for (int k = 1; k <= len; k++) begin
            tick();
            trig_in = (k == rr);
            if (k == 2) begin
                num = 7;
                stp = 1;
                dly = 0;
            end
            hi = 0;
            pc = 0;
            for (int i = 0; i < n; i++) begin
                if (k >= first + i * p && k < first + i * p + 4) hi = 1;
                if (k > first + i * p) pc++;
            end
            cyc = k;
            check("trig", 32'(o_trig), hi);
            check("busy", 32'(o_busy), 32'(n != 0 && k <= last + 3));
            check("done", 32'(o_done), 32'((n == 0) ? (k == 1) : (k == last + 4)));
            check("cnt", o_cnt, pc);
        end
    endtask

    task automatic run_burst(input int n, input int s, input int d, input int rr);
        num     = n;
        stp     = s;
        dly     = 16'(d);
        trig_in = 1'b1;
        check_burst(n, s, d, rr);
    endtask

    initial begin
        rst_n   = 1'b0;
        trig_in = 1'b0;
        abort   = 1'b0;
        num     = 0;
        stp     = 0;
        dly     = 0;
        tick();
        tick();
        check("rst_trig", 32'(o_trig), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_cnt", o_cnt, 0);
        rst_n = 1'b1;
        tick();
        run_burst(3, 10, 0, 0);
        run_burst(1, 0, 5, 3);
        run_burst(2, 2, 0, 0);
        run_burst(0, 10, 3, 0);
        run_burst(2, 6, 2, 0);
        // abort in the middle of the 2nd pulse
        num     = 5;
        stp     = 10;
        dly     = 0;
        trig_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            trig_in = 1'b0;
        end
        cyc = 12;
        check("ab_trig_pre", 32'(o_trig), 1);
        check("ab_cnt_pre", o_cnt, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc = 13;
        check("ab_trig", 32'(o_trig), 0);
        check("ab_busy", 32'(o_busy), 0);
        check("ab_done", 32'(o_done), 0);
        check("ab_cnt", o_cnt, 2);
        for (int k = 14; k < 34; k++) begin
            tick();
            cyc = k;
            check("ab_post_done", 32'(o_done), 0);
            check("ab_post_trig", 32'(o_trig), 0);
            check("ab_post_cnt", o_cnt, 2);
        end
        run_burst(2, 6, 1, 0);
        // reset during a gap, I_Trig_in held high across release
        num     = 3;
        stp     = 10;
        dly     = 0;
        trig_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            trig_in = 1'b0;
        end
        cyc = 6;
        check("gap_busy", 32'(o_busy), 1);
        check("gap_cnt", o_cnt, 1);
        rst_n   = 1'b0;
        trig_in = 1'b1;
        tick();
        cyc = 7;
        check("mrst_trig", 32'(o_trig), 0);
        check("mrst_busy", 32'(o_busy), 0);
        check("mrst_done", 32'(o_done), 0);
        check("mrst_cnt", o_cnt, 0);
        rst_n = 1'b1;
        check_burst(3, 10, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
